// File: rtl/fibonacci_ctrl.sv
// fibonacci_ctrl: sequences a fibonacci core, re-registers each term with its index, stops on count/wrap/abort
module fibonacci_ctrl #(
  parameter int WIDTH = 12,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  input  logic             abort,
  output logic             ready,
  output logic             fib_rst,
  output logic             fib_enb,
  input  logic [WIDTH-1:0] fib_in,
  output logic [WIDTH-1:0] term,
  output logic             term_valid,
  output logic [CNT_W-1:0] term_idx,
  output logic             done,
  output logic             ovf
);
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q, n_lat_q, term_idx_q;
  logic [WIDTH-1:0] term_q;
  logic             term_valid_q, ovf_q, last, wrap;
  assign last       = cnt_q == n_lat_q - CNT_W'(1);
  // a fibonacci term smaller than its predecessor can only come from a 12-bit wrap
  assign wrap       = cnt_q != '0 && fib_in < term_q;
  assign ready      = state_q == IDLE;
  assign done       = state_q == DONE;
  assign fib_rst    = rst | (state_q == CLEAR);
  assign fib_enb    = ~rst & (state_q == RUN) & ~abort & ~last;
  assign term       = term_q;
  assign term_valid = term_valid_q;
  assign term_idx   = term_idx_q;
  assign ovf        = ovf_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      n_lat_q      <= '0;
      term_q       <= '0;
      term_idx_q   <= '0;
      term_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      term_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          n_lat_q <= n_terms;
          ovf_q   <= 1'b0;
          cnt_q   <= '0;
          state_q <= n_terms != '0 ? CLEAR : DONE;
        end
        CLEAR: state_q <= abort ? DONE : RUN;
        RUN: if (abort) begin
          state_q <= DONE;
        end else if (wrap) begin
          ovf_q   <= 1'b1;
          state_q <= DONE;
        end else begin
          term_q       <= fib_in;
          term_idx_q   <= cnt_q;
          term_valid_q <= 1'b1;
          cnt_q        <= cnt_q + 1'b1;
          state_q      <= last ? DONE : RUN;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fibonacci_ctrl.sv
// tb_fibonacci_ctrl: directed scenarios against a behavioural fibonacci core
module tb_fibonacci_ctrl;
  logic        clk, rst, start, abort, ready, fib_rst, fib_enb, term_valid, done, ovf;
  logic [4:0]  n_terms, term_idx;
  logic [11:0] fib_in, term, fa, fb;
  int          checks = 0, errors = 0;
  logic [11:0] fibs [19] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610, 987, 1597, 2584};
  logic [11:0] q_term [$];
  logic [4:0]  q_idx [$];
  int          n_done, n_frst, n_enb, cyc_no, first_tv;
  logic        done_tv;
  logic [11:0] done_term;

  fibonacci_ctrl #(.WIDTH(12), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .n_terms(n_terms), .abort(abort),
    .ready(ready), .fib_rst(fib_rst), .fib_enb(fib_enb), .fib_in(fib_in),
    .term(term), .term_valid(term_valid), .term_idx(term_idx), .done(done), .ovf(ovf)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // core model: registered fibout, rst loads F0 with F1 queued
  always @(posedge clk) begin
    if (fib_rst) begin
      fa <= 12'd0;
      fb <= 12'd1;
    end else if (fib_enb) begin
      fa <= fb;
      fb <= fa + fb;
    end
  end
  assign fib_in = fa;

  task automatic clr_mon();
    q_term.delete();
    q_idx.delete();
    n_done = 0; n_frst = 0; n_enb = 0; cyc_no = 0; first_tv = -1; done_tv = 0; done_term = 0;
  endtask

  task automatic cyc();
    @(negedge clk);
    cyc_no++;
    if (term_valid) begin
      q_term.push_back(term);
      q_idx.push_back(term_idx);
      if (first_tv < 0) first_tv = cyc_no;
    end
    if (done) begin
      n_done++;
      done_tv = term_valid;
      done_term = term;
    end
    if (fib_rst) n_frst++;
    if (fib_enb) n_enb++;
  endtask

  task automatic wait_done(input string tag);
    for (int k = 0; k < 80 && n_done == 0; k++) cyc();
    checks++;
    if (n_done == 0) begin errors++; $display("FAIL %s_timeout: no done within 80 cycles", tag); end
  endtask

  task automatic run_req(input logic [4:0] n, input string tag);
    clr_mon();
    start = 1; n_terms = n;
    cyc();
    start = 0; n_terms = 5'd31;
    wait_done(tag);
    cyc(); cyc();
  endtask

  task automatic chk_terms(input string tag, input int exp_n);
    checks++;
    if (q_term.size() != exp_n) begin errors++; $display("FAIL %s_count: got %0d exp %0d", tag, q_term.size(), exp_n); end
    for (int i = 0; i < q_term.size() && i < 19; i++) begin
      checks++;
      if (q_term[i] !== fibs[i] || q_idx[i] !== 5'(i)) begin
        errors++;
        $display("FAIL %s_term%0d: got %0d idx %0d exp %0d idx %0d", tag, i, q_term[i], q_idx[i], fibs[i], i);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1; start = 0; abort = 0; n_terms = 0;
    clr_mon();
    cyc(); cyc();
    checks++;
    if ({ready, fib_rst, fib_enb, term_valid, done, ovf} !== 6'b110000) begin
      errors++; $display("FAIL reset_flags: got %b exp 110000", {ready, fib_rst, fib_enb, term_valid, done, ovf});
    end
    checks++;
    if (term !== 12'd0 || term_idx !== 5'd0) begin errors++; $display("FAIL reset_term: got %0d/%0d exp 0/0", term, term_idx); end
    rst = 0;
    cyc();
  endtask

  task automatic test_basic();
    run_req(5'd8, "basic");
    chk_terms("basic", 8);
    checks++;
    if (first_tv !== 3) begin errors++; $display("FAIL basic_latency: got %0d exp 3", first_tv); end
    checks++;
    if (n_done !== 1 || done_tv !== 1'b1 || done_term !== 12'd13) begin
      errors++; $display("FAIL basic_done: got n=%0d tv=%b term=%0d exp n=1 tv=1 term=13", n_done, done_tv, done_term);
    end
    checks++;
    if (ovf !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL basic_ovf_ready: got %b%b exp 01", ovf, ready); end
  endtask

  task automatic test_overflow();
    run_req(5'd25, "ovf");
    chk_terms("ovf", 19);
    checks++;
    if (done_tv !== 1'b0) begin errors++; $display("FAIL ovf_done_tv: got %b exp 0", done_tv); end
    checks++;
    if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b exp 1", ovf); end
  endtask

  task automatic test_zero_one();
    clr_mon();
    start = 1; n_terms = 0;
    cyc();
    start = 0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_done_latency: got %b exp 1", done); end
    cyc(); cyc();
    checks++;
    if (n_frst !== 0 || q_term.size() != 0 || ovf !== 1'b0) begin
      errors++; $display("FAIL zero_quiet: got frst=%0d terms=%0d ovf=%b exp 0 0 0", n_frst, q_term.size(), ovf);
    end
    run_req(5'd1, "one");
    chk_terms("one", 1);
    checks++;
    if (n_enb !== 0 || done_tv !== 1'b1) begin errors++; $display("FAIL one_enb: got enb=%0d tv=%b exp 0 1", n_enb, done_tv); end
  endtask

  task automatic test_abort();
    clr_mon();
    start = 1; n_terms = 10;
    cyc(); cyc(); cyc(); cyc();
    abort = 1;
    #1;
    checks++;
    if (fib_enb !== 1'b0) begin errors++; $display("FAIL abort_enb: got %b exp 0", fib_enb); end
    cyc();
    abort = 0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL abort_done: got %b exp 1", done); end
    start = 0;
    cyc(); cyc(); cyc();
    chk_terms("abort", 2);
    checks++;
    if (n_done !== 1 || ovf !== 1'b0 || ready !== 1'b1) begin
      errors++; $display("FAIL abort_end: got done=%0d ovf=%b ready=%b exp 1 0 1", n_done, ovf, ready);
    end
  endtask

  task automatic test_midrun_reset();
    clr_mon();
    start = 1; n_terms = 10;
    cyc();
    start = 0;
    for (int k = 0; k < 20 && q_term.size() < 4; k++) cyc();
    rst = 1;
    cyc();
    rst = 0;
    checks++;
    if (ready !== 1'b1 || term_valid !== 1'b0 || ovf !== 1'b0 || n_done !== 0) begin
      errors++; $display("FAIL midrst_state: got ready=%b tv=%b ovf=%b done=%0d exp 1 0 0 0", ready, term_valid, ovf, n_done);
    end
    chk_terms("midrst", 4);
    run_req(5'd3, "after_rst");
    chk_terms("after_rst", 3);
  endtask

  task automatic test_back_to_back();
    clr_mon();
    start = 1; n_terms = 20;
    cyc();
    wait_done("b2b1");
    chk_terms("b2b1", 19);
    n_terms = 3;
    cyc();
    checks++;
    if (ready !== 1'b1 || ovf !== 1'b1) begin errors++; $display("FAIL b2b_idle: got ready=%b ovf=%b exp 1 1", ready, ovf); end
    clr_mon();
    cyc();
    start = 0;
    checks++;
    if (ready !== 1'b0 || ovf !== 1'b0 || fib_rst !== 1'b1) begin
      errors++; $display("FAIL b2b_accept: got ready=%b ovf=%b frst=%b exp 0 0 1", ready, ovf, fib_rst);
    end
    wait_done("b2b2");
    cyc(); cyc();
    chk_terms("b2b2", 3);
    checks++;
    if (ovf !== 1'b0 || n_done !== 1) begin errors++; $display("FAIL b2b_end: got ovf=%b done=%0d exp 0 1", ovf, n_done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_zero_one();
    test_abort();
    test_midrun_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
